// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline front end: the bubble encoding,
// the fetch FSM states and the default reset PC.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Ready/valid instruction-memory port: the fetch stage is the master and
// the memory is the slave.
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: flush, then hold, then load, otherwise
// a bubble that keeps the last PC+4.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        write_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_plus4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;

    // IF/ID contents with flush > hold > load > bubble priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end else if (!write_i) begin
            valid_q    <= valid_q;
            instr_q    <= instr_q;
            pc_plus4_q <= pc_plus4_q;
        end else if (load_i) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
        end else begin
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
        end
    end

    assign valid_o    = valid_q;
    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and a two-state FSM that
// keeps the fetch address stable until an abandoned request has drained.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pc_write,
    input  logic                     if_id_write,
    input  logic                     if_flush,
    input  logic                     pc_src,
    input  logic [31:0]              branch_target,
    if_fetch_stage_if.master         bus,
    output logic                     id_valid,
    output logic [31:0]              id_instr,
    output logic [31:0]              id_pc_plus4,
    output logic                     fetch_stall
);

    import pipeline_pkg::fetch_state_e;
    import pipeline_pkg::FETCH;
    import pipeline_pkg::DRAIN;
    import pipeline_pkg::align_word;

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pending_q;

    logic         redirect;
    logic [31:0]  target;
    logic         fetch_done;

    assign redirect   = !pc_src && pc_write;
    assign target     = align_word(branch_target);
    assign fetch_done = (state_q == FETCH) && bus.imem_ready;

    // PC, pending redirect target and fetch FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pending_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect && bus.imem_ready) begin
                        pc_q <= target;
                    end else if (redirect) begin
                        // request already issued; park the target until it drains
                        pending_q <= target;
                        state_q   <= DRAIN;
                    end else if (pc_write && bus.imem_ready) begin
                        pc_q <= pc_q + 32'd4;
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ready) begin
                        pc_q    <= redirect ? target : pending_q;
                        state_q <= FETCH;
                    end else if (redirect) begin
                        pending_q <= target;
                    end else begin
                        pending_q <= pending_q;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req  = rst_n;
    assign bus.imem_addr = pc_q;
    assign fetch_stall   = (state_q == DRAIN) || !bus.imem_ready;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (if_flush),
        .write_i    (if_id_write),
        .load_i     (fetch_done && !redirect && pc_write),
        .instr_i    (bus.imem_rdata),
        .pc_plus4_i (pc_q + 32'd4),
        .valid_o    (id_valid),
        .instr_o    (id_instr),
        .pc_plus4_o (id_pc_plus4)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a behavioural fetch model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write, if_id_write, if_flush, pc_src;
    logic [31:0] branch_target;
    logic        id_valid, fetch_stall;
    logic [31:0] id_instr, id_pc_plus4;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_flush      (if_flush),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .bus           (bus),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_pc_plus4   (id_pc_plus4),
        .fetch_stall   (fetch_stall)
    );

    always #5 clk = ~clk;

    // Memory contents: a recognisable word derived from the address.
    function automatic logic [31:0] mw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
    endfunction

    assign bus.imem_rdata = mw(bus.imem_addr);

    // Reference model state
    logic [31:0] m_pc, m_pend, m_instr, m_p4;
    logic        m_drain, m_valid;
    int          wait_cnt;
    int          lat = 1;

    // Model: what the fetch stage must hold after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_pend <= 32'h0; m_drain <= 1'b0;
            m_valid <= 1'b0; m_instr <= 32'h0; m_p4 <= 32'h0; wait_cnt <= 0;
        end else begin
            if (if_flush) begin
                m_valid <= 1'b0; m_instr <= 32'h0;
            end else if (if_id_write) begin
                if (!m_drain && bus.imem_ready && pc_write && pc_src) begin
                    m_valid <= 1'b1; m_instr <= mw(m_pc); m_p4 <= m_pc + 32'd4;
                end else begin
                    m_valid <= 1'b0; m_instr <= 32'h0;
                end
            end
            if (!m_drain) begin
                if (pc_write && !pc_src) begin
                    if (bus.imem_ready) m_pc <= branch_target & 32'hFFFF_FFFC;
                    else begin m_pend <= branch_target & 32'hFFFF_FFFC; m_drain <= 1'b1; end
                end else if (pc_write && bus.imem_ready) m_pc <= m_pc + 32'd4;
            end else if (bus.imem_ready) begin
                m_pc <= (pc_write && !pc_src) ? (branch_target & 32'hFFFF_FFFC) : m_pend;
                m_drain <= 1'b0;
            end else if (pc_write && !pc_src) m_pend <= branch_target & 32'hFFFF_FFFC;
            wait_cnt <= bus.imem_ready ? 0 : wait_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("imem_req", {31'h0, bus.imem_req}, 32'h1);
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("fetch_stall", {31'h0, fetch_stall}, {31'h0, m_drain || !bus.imem_ready});
            chk("id_valid", {31'h0, id_valid}, {31'h0, m_valid});
            chk("id_instr", id_instr, m_instr);
            chk("id_pc_plus4", id_pc_plus4, m_p4);
        end
    end

    task automatic cyc(input logic pw, input logic iw, input logic fl, input logic ps,
                       input logic [31:0] bt);
        pc_write = pw; if_id_write = iw; if_flush = fl; pc_src = ps; branch_target = bt;
        bus.imem_ready = (wait_cnt + 1 >= lat);
        @(posedge clk);
        #2;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; if_flush = 1'b0;
        pc_src = 1'b1; branch_target = 32'h0; bus.imem_ready = 1'b1;
        #3;
        chk("rst imem_req", {31'h0, bus.imem_req}, 32'h0);
        chk("rst imem_addr", bus.imem_addr, 32'h0);
        chk("rst id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst id_instr", id_instr, 32'h0);
        chk("rst id_pc_plus4", id_pc_plus4, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; chk_en = 1'b1;

        // Back-to-back sequential fetch
        lat = 1;
        seq(1);
        chk("seq first valid", {31'h0, id_valid}, 32'h1);
        chk("seq first pc4", id_pc_plus4, 32'h4);
        chk("seq first instr", id_instr, mw(32'h0));
        seq(3);
        chk("seq addr", bus.imem_addr, 32'h10);
        chk("seq pc4", id_pc_plus4, 32'h10);

        // Three-cycle memory latency
        lat = 3;
        seq(1);
        chk("lat3 bubble", {31'h0, id_valid}, 32'h0);
        chk("lat3 addr held", bus.imem_addr, 32'h10);
        seq(2);
        chk("lat3 addr next", bus.imem_addr, 32'h14);
        chk("lat3 pc4", id_pc_plus4, 32'h14);
        seq(3);

        // Redirect with the response ready in the same cycle
        lat = 1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h41);
        chk("redir addr", bus.imem_addr, 32'h40);
        chk("redir bubble", {31'h0, id_valid}, 32'h0);
        seq(1);
        chk("redir pc4", id_pc_plus4, 32'h44);
        chk("redir instr", id_instr, mw(32'h40));

        // Two redirects while a fetch is outstanding
        lat = 4;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'hC0);
        chk("drain addr held", bus.imem_addr, 32'h44);
        seq(2);
        chk("drain new addr", bus.imem_addr, 32'hC0);
        chk("drain no stale", {31'h0, id_valid}, 32'h0);
        seq(4);
        chk("drain pc4", id_pc_plus4, 32'hC4);
        chk("drain instr", id_instr, mw(32'hC0));

        // Load-use stall, then flush together with hold
        lat = 1;
        seq(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("stall addr", bus.imem_addr, 32'hC8);
        chk("stall pc4 held", id_pc_plus4, 32'hC8);
        seq(1);
        chk("stall resume pc4", id_pc_plus4, 32'hCC);
        chk("stall resume instr", id_instr, mw(32'hC8));
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("flush beats hold", {31'h0, id_valid}, 32'h0);

        // PC+4 wrap at the top of the address space
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
        seq(1);
        chk("wrap pc4", id_pc_plus4, 32'h0);
        chk("wrap next addr", bus.imem_addr, 32'h0);

        // Reset asserted while draining
        lat = 5;
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h100);
        seq(1);
        rst_n = 1'b0;
        #1;
        chk("drain rst req", {31'h0, bus.imem_req}, 32'h0);
        chk("drain rst addr", bus.imem_addr, 32'h0);
        chk("drain rst valid", {31'h0, id_valid}, 32'h0);
        chk("drain rst pc4", id_pc_plus4, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; lat = 1;
        seq(3);
        chk("post rst addr", bus.imem_addr, 32'hC);
        chk("post rst pc4", id_pc_plus4, 32'hC);
        chk("post rst instr", id_instr, mw(32'h8));

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
